// File: rtl/mux4_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
// Imported by the dwell timer and the controller top.
package mux4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  // A single-cycle dwell still needs a 1-bit counter.
  function automatic int cnt_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/mux4_dwell_timer.sv
// Dwell counter: holds each select value DWELL cycles.
// last is high on the final dwell cycle of the current channel.
module mux4_dwell_timer
  import mux4_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] TOP = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == TOP);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux4to1_1b.sv
// 1-bit 4:1 multiplexer driven by the scan controller.
// F follows A[{S1,S0}] combinationally.
module mux4to1_1b (
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic S1,
  input  logic S0,
  output logic F
);

  assign F = S1 ? (S0 ? A3 : A2)
                : (S0 ? A1 : A0);

endmodule

// File: rtl/mux4to1_scan_ctrl.sv
// Drives a word onto a 4:1 mux, scans all selects,
// and returns the sampled F per channel plus a mismatch mask.
module mux4to1_scan_ctrl
  import mux4_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       S1,
  output logic       S0,
  input  logic       F,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [3:0] out_err
);

  state_t state_q;
  state_t state_d;

  logic [SEL_W-1:0]  ch_q;
  logic [SEL_W-1:0]  ch_d;
  logic [NUM_CH-1:0] a_q;
  logic [NUM_CH-1:0] a_d;
  logic [NUM_CH-1:0] data_q;
  logic [NUM_CH-1:0] data_d;
  logic [NUM_CH-1:0] err_q;
  logic [NUM_CH-1:0] err_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_last;

  mux4_dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .last  (tmr_last)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    a_d     = a_q;
    data_d  = data_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_data;
          ch_d    = '0;
          data_d  = '0;
          err_d   = '0;
          tmr_clr = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        tmr_en = 1'b1;
        // F only matters on the dwell-final edge.
        if (tmr_last) begin
          data_d[ch_q] = F;
          err_d[ch_q]  = F ^ a_q[ch_q];
          ch_d         = ch_q + SEL_W'(1);
          if (ch_q == LAST_CH) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      a_q     <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      a_q     <= a_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SCAN);
  assign out_valid = (state_q == DONE);

  assign {S1, S0} = busy ? ch_q : '0;

  assign A0 = a_q[0];
  assign A1 = a_q[1];
  assign A2 = a_q[2];
  assign A3 = a_q[3];

  assign out_data = data_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_mux4to1_scan_ctrl.sv
// Scoreboard bench for the mux scan controller.
// Two instances: DWELL=2 and DWELL=1, sharing the input side.
module tb_mux4to1_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       fforce;
  logic       fval;
  logic       use1;

  logic       ir2, a0_2, a1_2, a2_2, a3_2, s1_2, s0_2;
  logic       f2, mf2, busy2, ov2;
  logic [3:0] od2, oe2;

  logic       ir1, a0_1, a1_1, a2_1, a3_1, s1_1, s0_1;
  logic       f1, mf1, busy1, ov1;
  logic [3:0] od1, oe1;

  logic       o_ir, o_s1, o_s0, o_busy, o_ov;
  logic [3:0] o_a, o_od, o_oe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_prev = 0;
  int acc_last = 0;

  logic [7:0] sb [$];

  always #5 clk = ~clk;

  assign f2 = fforce ? fval : mf2;
  assign f1 = fforce ? fval : mf1;

  mux4to1_scan_ctrl #(.DWELL(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .A0(a0_2), .A1(a1_2), .A2(a2_2), .A3(a3_2),
    .S1(s1_2), .S0(s0_2), .F(f2),
    .busy(busy2), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_err(oe2)
  );

  mux4to1_1b u_mux2 (
    .A0(a0_2), .A1(a1_2), .A2(a2_2), .A3(a3_2),
    .S1(s1_2), .S0(s0_2), .F(mf2)
  );

  mux4to1_scan_ctrl #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .A0(a0_1), .A1(a1_1), .A2(a2_1), .A3(a3_1),
    .S1(s1_1), .S0(s0_1), .F(f1),
    .busy(busy1), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_err(oe1)
  );

  mux4to1_1b u_mux1 (
    .A0(a0_1), .A1(a1_1), .A2(a2_1), .A3(a3_1),
    .S1(s1_1), .S0(s0_1), .F(mf1)
  );

  assign o_ir   = use1 ? ir1 : ir2;
  assign o_s1   = use1 ? s1_1 : s1_2;
  assign o_s0   = use1 ? s0_1 : s0_2;
  assign o_busy = use1 ? busy1 : busy2;
  assign o_ov   = use1 ? ov1 : ov2;
  assign o_a    = use1 ? {a3_1, a2_1, a1_1, a0_1}
                       : {a3_2, a2_2, a1_2, a0_2};
  assign o_od   = use1 ? od1 : od2;
  assign o_oe   = use1 ? oe1 : oe2;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic xfer(input logic [3:0] w, input int hold);
    int n;
    int dw;
    logic [15:0] slog;
    logic [15:0] sexp;
    logic [7:0]  e;
    dw = use1 ? 1 : 2;
    n = 0;
    while (!o_ir && n < 20) begin
      tick();
      n++;
    end
    check("in_ready", 32'(o_ir), 32'd1);
    e[7:4] = fforce ? {4{fval}} : w;
    e[3:0] = e[7:4] ^ w;
    sb.push_back(e);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    acc_prev = acc_last;
    acc_last = cyc;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    sexp = '0;
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < dw; r++) begin
        sexp = {sexp[13:0], 2'(k)};
      end
    end
    n = 0;
    slog = '0;
    while (!o_ov && n < 40) begin
      slog = {slog[13:0], o_s1, o_s0};
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(4 * dw));
    check("sel_seq", 32'(slog), 32'(sexp));
    check("a_word", 32'(o_a), 32'(w));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = h[0];
      in_data   = ~w;
      tick();
      check("bp_hold", {20'd0, o_ov, o_ir, o_busy, 1'b0, o_od, o_oe},
            {20'd0, 4'b1000, sb[0]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("out_data", 32'(o_od), 32'(sb[0][7:4]));
    check("out_err", 32'(o_oe), 32'(sb[0][3:0]));
    void'(sb.pop_front());
    tick();
    check("idle", 32'({o_ov, o_ir}), 32'(2'b01));
  endtask

  initial begin
    logic seen;
    int n;
    use1      = 1'b0;
    fforce    = 1'b0;
    fval      = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 4'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    check("rst_outs2", {16'd0, a3_2, a2_2, a1_2, a0_2, s1_2, s0_2,
          busy2, ov2, od2, oe2}, 32'd0);
    check("rst_outs1", {16'd0, a3_1, a2_1, a1_1, a0_1, s1_1, s0_1,
          busy1, ov1, od1, oe1}, 32'd0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("rst_in_ready", 32'(ir2), 32'd1);

    // Real mux
    xfer(4'b1010, 0);

    // Forced F
    fforce = 1'b1;
    fval   = 1'b0;
    xfer(4'b1111, 0);
    fval   = 1'b1;
    xfer(4'b0000, 0);
    fforce = 1'b0;

    // Backpressure
    xfer(4'b1100, 5);

    // Reset in the middle of a scan
    in_valid = 1'b1;
    in_data  = 4'b0011;
    tick();
    in_valid = 1'b0;
    n = 0;
    while ({s1_2, s0_2} != 2'b10 && n < 10) begin
      tick();
      n++;
    end
    check("scan_reach10", 32'({s1_2, s0_2}), 32'(2'b10));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_outs", {16'd0, a3_2, a2_2, a1_2, a0_2, s1_2, s0_2,
          busy2, ov2, od2, oe2}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= ov2;
      tick();
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    xfer(4'b0101, 0);

    // DWELL=1, back to back
    use1 = 1'b1;
    xfer(4'b0110, 0);
    xfer(4'b1001, 0);
    check("acc_period", 32'(acc_last - acc_prev), 32'd6);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
